boot_loader: RTL and testbench
==============================

# boot_loader

Descriptor-driven boot sequencer that sits between the ROM, the instruction-fetch backing memory, and the IM and DM arrays. On `system_enable` it walks a descriptor list in ROM and copies word blocks from the backing memory into IM or DM. It then releases the CPU through `cpu_enable`. It owns the IM and DM write ports only while `busy` is high; the top-level mux hands them back to the core once `cpu_enable` rises.

## Interface
- DW, 32, data word width (MEM, IM, DM).
- ROM_AW, 8, ROM address width. The descriptor table holds up to 256 entries.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- system_enable  in  1  start request; level-sampled in IDLE only.
- rom_enable, rom_read  out  1 each  ROM access strobes.
- rom_address  out  ROM_AW  descriptor index.
- rom_out  in  36  descriptor word.
- MEM_en, MEM_read, MEM_write  out  1 each  backing-memory strobes. MEM_write is tied 0.
- MEM_addr  out  14  source word address.
- MEM_data  in  DW  source data.
- IM_enable, IM_write  out  1 each  IM write strobes.
- IM_address  out  10  IM destination word address.
- IM_in  out  DW  IM write data.
- DM_enable, DM_write  out  1 each  DM write strobes.
- DM_address  out  15  DM destination word address.
- DM_in  out  DW  DM write data.
- cpu_enable  out  1  CPU run permission; sticky until reset.
- busy  out  1  high from leaving IDLE until reaching DONE or ERROR.
- done  out  1  sticky; load completed.
- error  out  1  sticky; reserved descriptor type, or table overrun.

## Operation
- Descriptor layout, rom_out[35:0]:
  - [35:34] type: 00 END, 01 copy to IM, 10 copy to DM, 11 reserved.
  - [33:20] src: MEM word address.
  - [19:10] dst: destination address; zero-extended to 15 bits for DM.
  - [9:0] n: word count minus 1, giving 1..1024 words.
- States: IDLE, ROM_RD, DECODE, MEM_RD, WR, DONE, ERROR.
- IDLE:
  - system_enable=1 -> ROM_RD with rom_address=0.
  - Otherwise stay in IDLE.
- ROM_RD: rom_enable=rom_read=1 -> DECODE.
- DECODE: rom_out is valid in this state.
  - END -> DONE.
  - Type 11 -> ERROR.
  - Copy types: latch src, dst, n and the target; reset the word counter to 0 -> MEM_RD.
- MEM_RD: MEM_en=MEM_read=1, MEM_addr=src+cnt (mod 2^14) -> WR.
- WR: MEM_data is valid in this state.
  - Target IM: IM_enable=IM_write=1, IM_address=dst+cnt (mod 2^10), IM_in=MEM_data.
  - Target DM: DM_enable=DM_write=1, DM_address={5'b0,dst}+cnt (mod 2^15), DM_in=MEM_data.
  - If cnt==n: rom_address+1 -> ROM_RD. If rom_address was 255 -> ERROR instead (overrun).
  - Else: cnt+1 -> MEM_RD.
- DONE: cpu_enable=1 and done=1; terminal until reset.
- ERROR: error=1; cpu_enable stays 0; terminal until reset.
- Address wrap is silent modular arithmetic; it is not an error.
- system_enable is ignored outside IDLE. Deasserting it mid-load does not abort the load.
- Write strobes are high only in WR, and only for the selected target. IM and DM are never both written in one cycle.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All strobes 0; cpu_enable, busy, done, error all 0.
  - rom_address, MEM_addr, IM_address and DM_address all 0; IM_in and DM_in all 0.
- Reset asserted mid-load aborts immediately. Partially written IM/DM contents are left as is.
- ROM and MEM read latency is 1: address/strobe sampled at edge k, data valid during cycle k+1.
- IM and DM capture write data at the rising edge that ends WR.
- Cycle counts from the first edge with system_enable=1 in IDLE:
  - Each descriptor costs 2 cycles (ROM_RD, DECODE).
  - Each copied word costs 2 cycles (MEM_RD, WR).
  - An END-only table reaches DONE after 3 edges.
  - Total to DONE = 2*(descriptors incl. END) + 2*(total words) + 1.
- busy falls on the same edge that sets done or error.

## Test plan
- Single IM copy:
  - Stimulus: ROM[0]={01, src=0, dst=128, n=3}, ROM[1]=END; MEM[0..3]=A0..A3.
  - Required: IM[128..131]=A0..A3; done=1 and cpu_enable=1 after exactly 2*2+2*4+1=13 edges; DM untouched.
- Mixed IM+DM:
  - Stimulus: ROM[0]={01, src=16, dst=0, n=0}, ROM[1]={10, src=20, dst=5, n=1}, ROM[2]=END.
  - Required: IM[0]=MEM[16]; DM[5..6]=MEM[20..21]; never IM_write&DM_write in the same cycle.
- Wrap-around:
  - Stimulus: src=16383, dst=1023, n=1, target IM.
  - Required: IM[1023]=MEM[16383]; IM[0]=MEM[0]; error=0.
- Reserved type:
  - Stimulus: ROM[0] type 11.
  - Required: error=1 and busy=0 after 3 edges; no MEM/IM/DM strobes ever asserted; cpu_enable=0.
- Reset mid-copy:
  - Stimulus: drop rst during the 2nd WR of a 4-word copy, then release; system_enable held 1.
  - Required: outputs go to reset values asynchronously; the load restarts from rom_address=0 and completes with correct contents.
- Overrun:
  - Stimulus: all 256 ROM entries are 1-word IM copies; no END.
  - Required: after entry 255's WR, error=1 and done=0.

Source files
------------

// File: rtl/boot_loader_if.sv
// Bus bundle between the boot sequencer and its ROM, backing memory, IM and DM.
// The master side is the boot_loader. The slave side is the surrounding memory system.
interface boot_loader_if #(
  parameter int DW     = 32,
  parameter int ROM_AW = 8
);
  logic              system_enable;
  logic              rom_enable;
  logic              rom_read;
  logic [ROM_AW-1:0] rom_address;
  logic [35:0]       rom_out;
  logic              MEM_en;
  logic              MEM_read;
  logic              MEM_write;
  logic [13:0]       MEM_addr;
  logic [DW-1:0]     MEM_data;
  logic              IM_enable;
  logic              IM_write;
  logic [9:0]        IM_address;
  logic [DW-1:0]     IM_in;
  logic              DM_enable;
  logic              DM_write;
  logic [14:0]       DM_address;
  logic [DW-1:0]     DM_in;
  logic              cpu_enable;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  system_enable, rom_out, MEM_data,
    output rom_enable, rom_read, rom_address,
    output MEM_en, MEM_read, MEM_write, MEM_addr,
    output IM_enable, IM_write, IM_address, IM_in,
    output DM_enable, DM_write, DM_address, DM_in,
    output cpu_enable, busy, done, error
  );

  modport slave (
    output system_enable, rom_out, MEM_data,
    input  rom_enable, rom_read, rom_address,
    input  MEM_en, MEM_read, MEM_write, MEM_addr,
    input  IM_enable, IM_write, IM_address, IM_in,
    input  DM_enable, DM_write, DM_address, DM_in,
    input  cpu_enable, busy, done, error
  );
endinterface

// File: rtl/boot_loader.sv
// Descriptor-driven boot sequencer that copies word blocks from backing memory into IM/DM,
// then releases the CPU. Strobes and addresses are registered from the next-state decode.
module boot_loader #(
  parameter int DW     = 32,
  parameter int ROM_AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROM_RD = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_WR     = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [ROM_AW-1:0] ROM_LAST = {ROM_AW{1'b1}};
  localparam logic [ROM_AW-1:0] ROM_ONE  = {{(ROM_AW-1){1'b0}}, 1'b1};

  state_e            state_r, state_s;
  logic [ROM_AW-1:0] rom_addr_r, rom_addr_s;
  logic [13:0]       src_r, src_s;
  logic [9:0]        dst_r, dst_s;
  logic [9:0]        n_r, n_s;
  logic [9:0]        cnt_r, cnt_s;
  logic              tgt_dm_r, tgt_dm_s;

  logic              rom_rd_r;
  logic              mem_rd_r;
  logic [13:0]       mem_addr_r;
  logic              im_wr_r;
  logic [9:0]        im_addr_r;
  logic              dm_wr_r;
  logic [14:0]       dm_addr_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;

  // State and descriptor/counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      rom_addr_r <= {ROM_AW{1'b0}};
      src_r      <= 14'd0;
      dst_r      <= 10'd0;
      n_r        <= 10'd0;
      cnt_r      <= 10'd0;
      tgt_dm_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      rom_addr_r <= rom_addr_s;
      src_r      <= src_s;
      dst_r      <= dst_s;
      n_r        <= n_s;
      cnt_r      <= cnt_s;
      tgt_dm_r   <= tgt_dm_s;
    end
  end

  // Next-state and next-descriptor decode.
  always_comb begin
    state_s    = state_r;
    rom_addr_s = rom_addr_r;
    src_s      = src_r;
    dst_s      = dst_r;
    n_s        = n_r;
    cnt_s      = cnt_r;
    tgt_dm_s   = tgt_dm_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.system_enable) begin
          state_s    = ST_ROM_RD;
          rom_addr_s = {ROM_AW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ROM_RD: state_s = ST_DECODE;
      ST_DECODE: begin
        case (bus.rom_out[35:34])
          2'b00: state_s = ST_DONE;
          2'b01, 2'b10: begin
            state_s  = ST_MEM_RD;
            src_s    = bus.rom_out[33:20];
            dst_s    = bus.rom_out[19:10];
            n_s      = bus.rom_out[9:0];
            cnt_s    = 10'd0;
            tgt_dm_s = bus.rom_out[35];
          end
          default: state_s = ST_ERROR;
        endcase
      end
      ST_MEM_RD: state_s = ST_WR;
      ST_WR: begin
        if (cnt_r == n_r) begin
          // Running off the end of the table without an END entry is fatal.
          if (rom_addr_r == ROM_LAST) begin
            state_s = ST_ERROR;
          end else begin
            state_s    = ST_ROM_RD;
            rom_addr_s = rom_addr_r + ROM_ONE;
          end
        end else begin
          state_s = ST_MEM_RD;
          cnt_s   = cnt_r + 10'd1;
        end
      end
      ST_DONE:  state_s = ST_DONE;
      ST_ERROR: state_s = ST_ERROR;
      default:  state_s = ST_ERROR;
    endcase
  end

  // Output registers, decoded from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_rd_r   <= 1'b0;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= 14'd0;
      im_wr_r    <= 1'b0;
      im_addr_r  <= 10'd0;
      dm_wr_r    <= 1'b0;
      dm_addr_r  <= 15'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      rom_rd_r   <= (state_s == ST_ROM_RD);
      mem_rd_r   <= (state_s == ST_MEM_RD);
      mem_addr_r <= (state_s == ST_MEM_RD) ? (src_s + {4'd0, cnt_s}) : 14'd0;
      im_wr_r    <= (state_s == ST_WR) && !tgt_dm_s;
      im_addr_r  <= ((state_s == ST_WR) && !tgt_dm_s) ? (dst_s + cnt_s) : 10'd0;
      dm_wr_r    <= (state_s == ST_WR) && tgt_dm_s;
      dm_addr_r  <= ((state_s == ST_WR) && tgt_dm_s) ?
                    ({5'd0, dst_s} + {5'd0, cnt_s}) : 15'd0;
      busy_r     <= (state_s == ST_ROM_RD) || (state_s == ST_DECODE) ||
                    (state_s == ST_MEM_RD) || (state_s == ST_WR);
      done_r     <= (state_s == ST_DONE);
      error_r    <= (state_s == ST_ERROR);
    end
  end

  assign bus.rom_enable  = rom_rd_r;
  assign bus.rom_read    = rom_rd_r;
  assign bus.rom_address = rom_addr_r;
  assign bus.MEM_en      = mem_rd_r;
  assign bus.MEM_read    = mem_rd_r;
  assign bus.MEM_write   = 1'b0;
  assign bus.MEM_addr    = mem_addr_r;
  assign bus.IM_enable   = im_wr_r;
  assign bus.IM_write    = im_wr_r;
  assign bus.IM_address  = im_addr_r;
  assign bus.DM_enable   = dm_wr_r;
  assign bus.DM_write    = dm_wr_r;
  assign bus.DM_address  = dm_addr_r;
  // Read data arrives during WR itself, so write data is a gated pass-through.
  assign bus.IM_in       = im_wr_r ? bus.MEM_data : {DW{1'b0}};
  assign bus.DM_in       = dm_wr_r ? bus.MEM_data : {DW{1'b0}};
  assign bus.cpu_enable  = done_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.error       = error_r;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected IM/DM writes are queued per test and a
// negedge monitor pops and compares each write the DUT issues.
`timescale 1ns/1ps
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_loader_if #(.DW(32), .ROM_AW(8)) bus();
  boot_loader #(.DW(32), .ROM_AW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [35:0] rom_mem [256];
  logic [31:0] mem_arr [16384];
  logic [31:0] im_arr  [1024];
  logic [31:0] dm_arr  [32768];
  logic [47:0] exp_q   [$];
  int total      = 0;
  int passed     = 0;
  int strobe_cnt = 0;
  int edges      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [35:0] desc(input logic [1:0] t, input logic [13:0] s,
                                       input logic [9:0] d, input logic [9:0] n);
    return {t, s, d, n};
  endfunction

  task automatic push_wr(input logic dm, input logic [14:0] addr, input logic [31:0] data);
    exp_q.push_back({dm, addr, data});
  endtask

  // Memory models: 1-cycle read latency, writes captured at the edge ending WR.
  always @(posedge clk) begin
    if (bus.rom_enable && bus.rom_read) bus.rom_out <= rom_mem[bus.rom_address];
    if (bus.MEM_en && bus.MEM_read) bus.MEM_data <= mem_arr[bus.MEM_addr];
    if (bus.IM_enable && bus.IM_write) im_arr[bus.IM_address] <= bus.IM_in;
    if (bus.DM_enable && bus.DM_write) dm_arr[bus.DM_address] <= bus.DM_in;
  end

  // Monitor: pop one expectation per observed write.
  always @(negedge clk) begin
    logic [47:0] act;
    logic [47:0] e;
    if (rst) begin
      if (bus.MEM_en || bus.MEM_read || bus.IM_enable || bus.IM_write ||
          bus.DM_enable || bus.DM_write) strobe_cnt++;
      if (bus.IM_write && bus.DM_write) begin
        chk("im_dm_same_cycle", 64'd1, 64'd0);
      end else if ((bus.IM_enable && bus.IM_write) || (bus.DM_enable && bus.DM_write)) begin
        act = bus.DM_write ? {1'b1, bus.DM_address, bus.DM_in}
                           : {1'b0, 5'd0, bus.IM_address, bus.IM_in};
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk("write", {16'd0, act}, {16'd0, e});
        end
      end
    end
  end

  task automatic check_reset_vals(input string nm);
    chk({nm, "_rst_strobes"}, {55'd0, bus.rom_enable, bus.rom_read, bus.MEM_en, bus.MEM_read,
        bus.MEM_write, bus.IM_enable, bus.IM_write, bus.DM_enable, bus.DM_write}, 64'd0);
    chk({nm, "_rst_flags"}, {60'd0, bus.cpu_enable, bus.busy, bus.done, bus.error}, 64'd0);
    chk({nm, "_rst_addrs"}, {17'd0, bus.rom_address, bus.MEM_addr, bus.IM_address,
        bus.DM_address}, 64'd0);
    chk({nm, "_rst_data"}, {bus.IM_in, bus.DM_in}, 64'd0);
  endtask

  // Assert reset, check outputs, and clear the memory models and scoreboard.
  task automatic setup(input string nm);
    rst = 1'b0;
    bus.system_enable = 1'b0;
    #1;
    check_reset_vals(nm);
    for (int i = 0; i < 256; i++) rom_mem[i] = 36'd0;
    for (int i = 0; i < 16384; i++) mem_arr[i] = 32'd0;
    for (int i = 0; i < 1024; i++) im_arr[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 32768; i++) dm_arr[i] = 32'hDEAD_BEEF;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic start_load();
    rst = 1'b1;
    strobe_cnt = 0;
    bus.system_enable = 1'b1;
  endtask

  // Count edges from the first edge with system_enable seen in IDLE.
  task automatic wait_end(input int bound, input int start, output int n_edges);
    n_edges = start;
    while (n_edges < bound) begin
      @(posedge clk);
      n_edges++;
      #1;
      if (bus.done || bus.error) break;
    end
    @(negedge clk);
  endtask

  task automatic chk_flags(input string nm, input logic [3:0] exp);
    chk(nm, {60'd0, bus.cpu_enable, bus.done, bus.error, bus.busy}, {60'd0, exp});
  endtask

  initial begin
    #1;
    // END-only table
    setup("end");
    start_load();
    wait_end(50, 0, edges);
    chk("end_cycles", edges, 3);
    chk_flags("end_flags", 4'b1100);

    // Single IM copy
    setup("im");
    rom_mem[0] = desc(2'b01, 14'd0, 10'd128, 10'd3);
    for (int i = 0; i < 4; i++) begin
      mem_arr[i] = 32'h0000_00A0 + i;
      push_wr(1'b0, 15'(128 + i), 32'h0000_00A0 + i);
    end
    start_load();
    wait_end(100, 0, edges);
    chk("im_cycles", edges, 13);
    chk_flags("im_flags", 4'b1100);
    chk("im_128", im_arr[128], 32'h0000_00A0);
    chk("im_131", im_arr[131], 32'h0000_00A3);
    chk("im_dm_untouched", dm_arr[128], 32'hDEAD_BEEF);
    chk("im_queue_empty", exp_q.size(), 0);

    // Mixed IM+DM; system_enable dropped after the first edge must not abort
    setup("mix");
    rom_mem[0] = desc(2'b01, 14'd16, 10'd0, 10'd0);
    rom_mem[1] = desc(2'b10, 14'd20, 10'd5, 10'd1);
    mem_arr[16] = 32'h1111_0016;
    mem_arr[20] = 32'h2222_0020;
    mem_arr[21] = 32'h3333_0021;
    push_wr(1'b0, 15'd0, 32'h1111_0016);
    push_wr(1'b1, 15'd5, 32'h2222_0020);
    push_wr(1'b1, 15'd6, 32'h3333_0021);
    start_load();
    @(posedge clk);
    #1 bus.system_enable = 1'b0;
    wait_end(100, 1, edges);
    chk("mix_cycles", edges, 13);
    chk_flags("mix_flags", 4'b1100);
    chk("mix_im0", im_arr[0], 32'h1111_0016);
    chk("mix_dm6", dm_arr[6], 32'h3333_0021);
    chk("mix_queue_empty", exp_q.size(), 0);

    // Address wrap
    setup("wrap");
    rom_mem[0] = desc(2'b01, 14'd16383, 10'd1023, 10'd1);
    mem_arr[16383] = 32'hCAFE_3FFF;
    mem_arr[0]     = 32'hF00D_0000;
    push_wr(1'b0, 15'd1023, 32'hCAFE_3FFF);
    push_wr(1'b0, 15'd0, 32'hF00D_0000);
    start_load();
    wait_end(100, 0, edges);
    chk("wrap_cycles", edges, 9);
    chk_flags("wrap_flags", 4'b1100);
    chk("wrap_im1023", im_arr[1023], 32'hCAFE_3FFF);
    chk("wrap_im0", im_arr[0], 32'hF00D_0000);

    // Reserved descriptor type
    setup("rsv");
    rom_mem[0] = desc(2'b11, 14'd1, 10'd2, 10'd3);
    start_load();
    wait_end(50, 0, edges);
    chk("rsv_cycles", edges, 3);
    chk_flags("rsv_flags", 4'b0010);
    chk("rsv_no_strobes", strobe_cnt, 0);

    // Reset during the 2nd WR of a 4-word copy, then automatic restart
    setup("mid");
    rom_mem[0] = desc(2'b01, 14'd100, 10'd200, 10'd3);
    for (int i = 0; i < 4; i++) mem_arr[100 + i] = 32'h5A00_0000 + i;
    push_wr(1'b0, 15'd200, 32'h5A00_0000);
    for (int i = 0; i < 4; i++) push_wr(1'b0, 15'(200 + i), 32'h5A00_0000 + i);
    start_load();
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("mid");
    @(negedge clk);
    rst = 1'b1;
    wait_end(100, 0, edges);
    chk("mid_cycles", edges, 13);
    chk_flags("mid_flags", 4'b1100);
    chk("mid_im201", im_arr[201], 32'h5A00_0001);
    chk("mid_im203", im_arr[203], 32'h5A00_0003);
    chk("mid_queue_empty", exp_q.size(), 0);

    // Table overrun: 256 one-word copies, no END
    setup("ovr");
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = desc(2'b01, 14'(i), 10'(i), 10'd0);
      mem_arr[i] = 32'h7700_0000 + i;
      push_wr(1'b0, 15'(i), 32'h7700_0000 + i);
    end
    start_load();
    wait_end(2000, 0, edges);
    chk("ovr_cycles", edges, 1025);
    chk_flags("ovr_flags", 4'b0010);
    chk("ovr_im255", im_arr[255], 32'h7700_00FF);
    chk("ovr_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
